// File: rtl/seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl
//   Accepts 8-bit words, serializes them MSB first, and runs a 4-bit pattern
//   detector over the resulting bit stream. Matches are pulsed on seq_seen,
//   counted in a saturating counter, and raise a sticky threshold interrupt.
//
// Handshake: a word is accepted on any rising edge where word_valid and
//   word_ready are both high. word_valid may be held; word_ready may drop
//   without notice. A bit is consumed on every edge where ser_valid is high.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   word_in      in   [7:0] parallel word, MSB serialized first
//   word_valid   in   word_in valid
//   word_ready   out  word_in accepted this cycle if word_valid
//   enable       in   low pauses serialization (all state holds)
//   pattern      in   [3:0] target pattern, oldest bit in [3]; latched on accept
//   thresh       in   [7:0] match count that raises irq; 0 disables irq
//   hist_clr     in   flush bit history
//   irq_clr      in   clear irq and match_cnt
//   ser_bit      out  bit presented to the detector
//   ser_valid    out  ser_bit consumed this cycle
//   seq_seen     out  one-cycle pulse, cycle after a matching consume
//   match_cnt    out  [7:0] saturating match count
//   irq          out  sticky interrupt, match_cnt reached thresh
//   dbg_state    out  FSM state (0 = IDLE, 1 = SHIFT)
//   dbg_bit_cnt  out  [2:0] index of the bit currently presented
// -----------------------------------------------------------------------------
module seq_detect_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] word_in,
  input  logic       word_valid,
  output logic       word_ready,
  input  logic       enable,
  input  logic [3:0] pattern,
  input  logic [7:0] thresh,
  input  logic       hist_clr,
  input  logic       irq_clr,
  output logic       ser_bit,
  output logic       ser_valid,
  output logic       seq_seen,
  output logic [7:0] match_cnt,
  output logic       irq,
  output logic       dbg_state,
  output logic [2:0] dbg_bit_cnt
);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_SHIFT = 1'b1;

  logic       r_state;
  logic       w_state_nxt;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_pat_q;
  logic [3:0] r_hist;
  logic [2:0] r_hist_fill;
  logic       r_seq_seen;
  logic [7:0] r_match_cnt;
  logic       r_irq;

  logic       w_word_ready;
  logic       w_ser_valid;
  logic       w_ser_bit;
  logic       w_accept;
  logic [3:0] w_hist_base;
  logic [2:0] w_fill_base;
  logic [3:0] w_hist_shift;
  logic       w_match;
  logic [7:0] w_cnt_base;
  logic [7:0] w_cnt_nxt;
  logic       w_irq_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: if (enable && (r_bit_cnt == 3'd0) && !w_accept) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic. word_ready is raised on the last bit of a word so the next
  // word loads with no idle cycle in between.
  always_comb begin
    w_word_ready = 1'b0;
    w_ser_valid  = 1'b0;
    w_ser_bit    = 1'b0;
    case (r_state)
      S_IDLE: w_word_ready = 1'b1;
      S_SHIFT: begin
        w_word_ready = enable && (r_bit_cnt == 3'd0);
        w_ser_valid  = enable;
        w_ser_bit    = r_shift[r_bit_cnt];
      end
      default: w_word_ready = 1'b0;
    endcase
  end

  assign w_accept = word_valid & w_word_ready;

  // A flush in the same cycle as a consume makes that bit the first one of
  // the new history, so the flush is applied before the shift.
  assign w_hist_base  = hist_clr ? 4'd0 : r_hist;
  assign w_fill_base  = hist_clr ? 3'd0 : r_hist_fill;
  assign w_hist_shift = {w_hist_base[2:0], w_ser_bit};
  assign w_match      = w_ser_valid && (w_hist_shift == r_pat_q) && (w_fill_base >= 3'd3);

  // irq_clr is applied before the increment so a coincident match counts as 1.
  assign w_cnt_base = irq_clr ? 8'd0 : r_match_cnt;
  assign w_cnt_nxt  = (w_match && (w_cnt_base != 8'hFF)) ? w_cnt_base + 8'd1 : w_cnt_base;
  assign w_irq_nxt  = (irq_clr ? 1'b0 : r_irq) | ((thresh != 8'd0) && (w_cnt_nxt >= thresh));

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift     <= 8'd0;
      r_bit_cnt   <= 3'd0;
      r_pat_q     <= 4'd0;
      r_hist      <= 4'd0;
      r_hist_fill <= 3'd0;
      r_seq_seen  <= 1'b0;
      r_match_cnt <= 8'd0;
      r_irq       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift   <= word_in;
        r_pat_q   <= pattern;
        r_bit_cnt <= 3'd7;
      end else if (w_ser_valid && (r_bit_cnt != 3'd0)) begin
        r_bit_cnt <= r_bit_cnt - 3'd1;
      end
      if (w_ser_valid) begin
        r_hist      <= w_hist_shift;
        r_hist_fill <= (w_fill_base == 3'd4) ? 3'd4 : w_fill_base + 3'd1;
      end else begin
        r_hist      <= w_hist_base;
        r_hist_fill <= w_fill_base;
      end
      r_seq_seen  <= w_match;
      r_match_cnt <= w_cnt_nxt;
      r_irq       <= w_irq_nxt;
    end
  end

  assign word_ready  = w_word_ready;
  assign ser_valid   = w_ser_valid;
  assign ser_bit     = w_ser_bit;
  assign seq_seen    = r_seq_seen;
  assign match_cnt   = r_match_cnt;
  assign irq         = r_irq;
  assign dbg_state   = r_state;
  assign dbg_bit_cnt = r_bit_cnt;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_ctrl
//   Table-driven vectors, directed multi-cycle sequences and randomized
//   stimulus for seq_detect_ctrl. A queue-based reference model (words as bit
//   queues, history as a bit queue) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_seq_detect_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset;
  logic [7:0] word_in;
  logic       word_valid;
  logic       word_ready;
  logic       enable;
  logic [3:0] pattern;
  logic [7:0] thresh;
  logic       hist_clr;
  logic       irq_clr;
  logic       ser_bit;
  logic       ser_valid;
  logic       seq_seen;
  logic [7:0] match_cnt;
  logic       irq;
  logic       dbg_state;
  logic [2:0] dbg_bit_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_detect_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .enable      (enable),
    .pattern     (pattern),
    .thresh      (thresh),
    .hist_clr    (hist_clr),
    .irq_clr     (irq_clr),
    .ser_bit     (ser_bit),
    .ser_valid   (ser_valid),
    .seq_seen    (seq_seen),
    .match_cnt   (match_cnt),
    .irq         (irq),
    .dbg_state   (dbg_state),
    .dbg_bit_cnt (dbg_bit_cnt)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  bit   m_bits[$];   // remaining bits of the current word, next bit at [0]
  bit   m_hist[$];   // up to 4 most recent consumed bits, oldest at [0]
  int   m_cnt;
  bit   m_irq;
  bit   m_seen;
  logic [3:0] m_pat;
  bit   m_known = 1'b0;

  // samples captured pre-edge in the most recent cycle
  logic       s_ready, s_sv, s_sb, s_seen, s_irq, s_state;
  logic [7:0] s_cnt;
  logic [2:0] s_bcnt;

  task automatic model_step(input logic rst, input logic valid, input logic [7:0] w,
                            input logic en, input logic [3:0] pat, input logic [7:0] th,
                            input logic hclr, input logic iclr);
    bit   in_shift, ready, accept, match, b;
    logic [3:0] h;
    if (rst) begin
      m_bits.delete(); m_hist.delete();
      m_cnt = 0; m_irq = 0; m_seen = 0; m_pat = 4'd0; m_known = 1'b1;
      return;
    end
    in_shift = (m_bits.size() != 0);
    ready    = !in_shift || (m_bits.size() == 1 && en);
    accept   = valid && ready;
    match    = 1'b0;
    if (hclr) m_hist.delete();
    if (in_shift && en) begin
      b = m_bits.pop_front();
      m_hist.push_back(b);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      if (m_hist.size() == 4) begin
        h = {m_hist[0], m_hist[1], m_hist[2], m_hist[3]};
        match = (h == m_pat);
      end
    end
    if (accept) begin
      for (int i = 7; i >= 0; i--) m_bits.push_back(w[i]);
      m_pat = pat;
    end
    if (iclr) begin m_cnt = 0; m_irq = 0; end
    if (match && m_cnt < 255) m_cnt++;
    if (th != 0 && m_cnt >= th) m_irq = 1;
    m_seen = match;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic rst, input logic valid, input logic [7:0] w,
                       input logic en, input logic [3:0] pat, input logic [7:0] th,
                       input logic hclr, input logic iclr);
    bit in_shift;
    reset = rst; word_valid = valid; word_in = w; enable = en;
    pattern = pat; thresh = th; hist_clr = hclr; irq_clr = iclr;
    #1;
    s_ready = word_ready; s_sv = ser_valid; s_sb = ser_bit; s_seen = seq_seen;
    s_irq = irq; s_cnt = match_cnt; s_state = dbg_state; s_bcnt = dbg_bit_cnt;
    if (m_known) begin
      in_shift = (m_bits.size() != 0);
      check("m_word_ready", s_ready, !in_shift || (m_bits.size() == 1 && en));
      check("m_ser_valid",  s_sv,    in_shift && en);
      check("m_ser_bit",    s_sb,    in_shift ? m_bits[0] : 1'b0);
      check("m_seq_seen",   s_seen,  m_seen);
      check("m_match_cnt",  s_cnt,   m_cnt);
      check("m_irq",        s_irq,   m_irq);
      check("m_state",      s_state, in_shift);
      check("m_bit_cnt",    s_bcnt,  in_shift ? m_bits.size() - 1 : 0);
    end
    model_step(rst, valid, w, en, pat, th, hclr, iclr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(1, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0);
  endtask

  // simple cycle: enable=1, no clears, reset low
  task automatic run(input logic valid, input logic [7:0] w, input logic [3:0] pat,
                     input logic [7:0] th);
    cycle(0, valid, w, 1, pat, th, 0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       valid;
    logic [7:0] word;
    logic       e_ready;
    logic       e_sv;
    logic       e_sb;
    logic       e_seen;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[10];

  int pulses;
  int pulse_at;

  initial begin
    // 0xB0 = 1011_0000, pattern 1011: match on 4th consume, pulse next cycle
    tbl[0] = '{1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};

    reset = 1; word_valid = 0; word_in = 0; enable = 0; pattern = 0;
    thresh = 0; hist_clr = 0; irq_clr = 0;
    do_reset();
    do_reset();

    // reset state
    run(0, 8'h00, 4'hB, 8'd0);
    check("rst_word_ready", s_ready, 1);
    check("rst_ser_valid",  s_sv,    0);
    check("rst_seq_seen",   s_seen,  0);
    check("rst_match_cnt",  s_cnt,   0);
    check("rst_irq",        s_irq,   0);

    // table: single match in 0xB0
    for (int i = 0; i < 10; i++) begin
      run(tbl[i].valid, tbl[i].word, 4'hB, 8'd0);
      check($sformatf("tbl%0d_ready", i), s_ready, tbl[i].e_ready);
      check($sformatf("tbl%0d_sv", i),    s_sv,    tbl[i].e_sv);
      check($sformatf("tbl%0d_sb", i),    s_sb,    tbl[i].e_sb);
      check($sformatf("tbl%0d_seen", i),  s_seen,  tbl[i].e_seen);
      check($sformatf("tbl%0d_cnt", i),   s_cnt,   tbl[i].e_cnt);
    end

    // 0xB6: overlapping matches after consumes 4 and 7
    do_reset();
    pulses = 0;
    run(1, 8'hB6, 4'hB, 8'd0);
    for (int i = 1; i < 11; i++) begin
      run(0, 8'h00, 4'hB, 8'd0);
      if (s_seen === 1'b1) pulses++;
    end
    check("b6_pulses", pulses, 2);
    check("b6_cnt",    s_cnt,  2);

    // 0x05 then 0x80 back-to-back: match spans the word boundary
    do_reset();
    pulses = 0; pulse_at = -1;
    run(1, 8'h05, 4'hB, 8'd0);                       // c0 accept
    for (int i = 1; i < 8; i++) run(0, 8'h00, 4'hB, 8'd0);
    run(1, 8'h80, 4'hB, 8'd0);                       // c8 last bit + accept
    check("b2b_ready_last_bit", s_ready, 1);
    for (int i = 9; i < 20; i++) begin
      run(0, 8'h00, 4'hB, 8'd0);
      if (s_seen === 1'b1) begin pulses++; pulse_at = i; end
    end
    check("b2b_pulses",   pulses,   1);
    check("b2b_pulse_at", pulse_at, 10);

    // enable low 3 cycles mid-word shifts the match by 3 cycles
    do_reset();
    pulse_at = -1;
    run(1, 8'hB0, 4'hB, 8'd0);                       // c0
    run(0, 8'h00, 4'hB, 8'd0);                       // c1 consume bit7
    for (int i = 2; i < 5; i++) begin
      cycle(0, 0, 8'h00, 0, 4'hB, 8'd0, 0, 0);
      check("pause_ser_valid", s_sv,   0);
      check("pause_bit_cnt",   s_bcnt, 6);
    end
    for (int i = 5; i < 14; i++) begin
      run(0, 8'h00, 4'hB, 8'd0);
      if (s_seen === 1'b1 && pulse_at < 0) pulse_at = i;
    end
    check("pause_pulse_at", pulse_at, 8);

    // thresh=2 with 0xB6, then irq_clr
    do_reset();
    run(1, 8'hB6, 4'hB, 8'd2);
    for (int i = 1; i < 8; i++) run(0, 8'h00, 4'hB, 8'd2);
    check("th2_irq_before", s_irq, 0);               // c7 sample
    run(0, 8'h00, 4'hB, 8'd2);                       // c8 sample
    check("th2_irq_set", s_irq, 1);
    check("th2_cnt",     s_cnt, 2);
    cycle(0, 0, 8'h00, 1, 4'hB, 8'd2, 0, 1);         // irq_clr
    run(0, 8'h00, 4'hB, 8'd2);
    check("iclr_irq", s_irq, 0);
    check("iclr_cnt", s_cnt, 0);

    // saturation: continuous zeros against pattern 0000, thresh 0
    do_reset();
    for (int i = 0; i < 330; i++) run(1, 8'h00, 4'h0, 8'd0);
    run(0, 8'h00, 4'h0, 8'd0);
    check("sat_cnt", s_cnt, 255);
    check("sat_irq", s_irq, 0);

    // irq_clr coincident with a match
    do_reset();
    for (int i = 0; i < 20; i++) run(1, 8'h00, 4'h0, 8'd3);
    cycle(0, 1, 8'h00, 1, 4'h0, 8'd3, 0, 1);
    run(1, 8'h00, 4'h0, 8'd3);
    check("iclr_match_cnt_th3", s_cnt, 1);
    check("iclr_match_irq_th3", s_irq, 0);
    run(1, 8'h00, 4'h0, 8'd3);
    run(1, 8'h00, 4'h0, 8'd3);
    check("th3_irq_again", s_irq, 1);
    cycle(0, 1, 8'h00, 1, 4'h0, 8'd1, 0, 1);
    run(1, 8'h00, 4'h0, 8'd1);
    check("iclr_match_cnt_th1", s_cnt, 1);
    check("iclr_match_irq_th1", s_irq, 1);

    // hist_clr coincident with the 3rd consume of 0xB0 suppresses the match
    do_reset();
    pulses = 0;
    run(1, 8'hB0, 4'hB, 8'd0);
    run(0, 8'h00, 4'hB, 8'd0);
    run(0, 8'h00, 4'hB, 8'd0);
    cycle(0, 0, 8'h00, 1, 4'hB, 8'd0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      run(0, 8'h00, 4'hB, 8'd0);
      if (s_seen === 1'b1) pulses++;
    end
    check("hclr_pulses", pulses, 0);

    // reset mid-word discards the partial word
    do_reset();
    run(1, 8'hB0, 4'hB, 8'd0);
    for (int i = 0; i < 3; i++) run(0, 8'h00, 4'hB, 8'd0);
    do_reset();
    run(0, 8'h00, 4'hB, 8'd0);
    check("midrst_ready", s_ready, 1);
    check("midrst_state", s_state, 0);
    check("midrst_cnt",   s_cnt,   0);
    pulses = 0;
    run(1, 8'hB0, 4'hB, 8'd0);
    for (int i = 0; i < 11; i++) begin
      run(0, 8'h00, 4'hB, 8'd0);
      if (s_seen === 1'b1) pulses++;
    end
    check("midrst_resend_pulses", pulses, 1);
    check("midrst_resend_cnt",    s_cnt,  1);

    // randomized stimulus against the reference model
    begin
      logic [7:0] th_r;
      th_r = 8'd3;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 99) == 0) th_r = 8'($urandom_range(0, 6));
        cycle($urandom_range(0, 299) == 0,
              $urandom_range(0, 1) == 1,
              8'($urandom_range(0, 255)),
              $urandom_range(0, 9) < 8,
              4'($urandom_range(0, 15)),
              th_r,
              $urandom_range(0, 29) == 0,
              $urandom_range(0, 39) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, reset.
REQ-002 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port word_in  input  8  parallel word to serialize, MSB first.
REQ-005 Port word_valid  input  1  word_in is valid.
REQ-006 Port word_ready  output  1  block accepts word_in this cycle.
REQ-007 Port enable  input  1  when low, serialization pauses.
REQ-008 Port pattern  input  4  target pattern, oldest bit in pattern[3].
REQ-009 Port thresh  input  8  match count at which irq sets; 0 disables irq.
REQ-010 Port hist_clr  input  1  one-cycle request to flush bit history.
REQ-011 Port irq_clr  input  1  one-cycle request to clear irq and match_cnt.
REQ-012 Port ser_bit  output  1  bit currently presented to the detector.
REQ-013 Port ser_valid  output  1  ser_bit is consumed this cycle.
REQ-014 Port seq_seen  output  1  registered one-cycle match pulse.
REQ-015 Port match_cnt  output  8  saturating count of matches.
REQ-016 Port irq  output  1  level interrupt, threshold reached.

Function
REQ-017 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-018 word_ready SHALL be 1 in IDLE, and in SHIFT only when bit_cnt==0 and enable==1 (back-to-back words, no bubble).
REQ-019 An accept (word_valid & word_ready) SHALL load word_in into a shift register, latch pattern into pat_q, set bit_cnt=7 and enter SHIFT.
REQ-020 In SHIFT: ser_bit SHALL equal the loaded word bit [bit_cnt], combinational from registers; ser_valid = enable.
REQ-021 In SHIFT with enable==1, bit_cnt SHALL decrement each cycle; with enable==0, all state SHALL hold.
REQ-022 After the bit_cnt==0 consume: no accept -> IDLE; accept -> reload, stay in SHIFT.
REQ-023 In IDLE: ser_valid=0, ser_bit=0.
REQ-024 On each consume, hist SHALL update to {hist[2:0],ser_bit}, and hist_fill (0..4) SHALL increment, saturating at 4.
REQ-025 A match SHALL occur on a consume where {hist[2:0],ser_bit}==pat_q and hist_fill>=3; overlapping matches count.
REQ-026 seq_seen SHALL be 1 in the cycle after a matching consume, otherwise 0.
REQ-027 History SHALL persist across word boundaries; matches may span words.
REQ-028 hist_clr SHALL zero hist and hist_fill next edge; a consume in that same cycle SHALL be evaluated as the first bit after the flush, with hist_fill ending at 1.
REQ-029 match_cnt SHALL increment on each match and saturate at 255.
REQ-030 irq SHALL set when thresh!=0 and match_cnt reaches >=thresh, and SHALL stay set until irq_clr.
REQ-031 irq_clr SHALL zero match_cnt and irq.
REQ-032 A match in the same cycle as irq_clr SHALL give match_cnt=1.
REQ-033 With irq_clr and a match in the same cycle, irq SHALL be 1 after the edge only if thresh==1.
REQ-034 pattern changes SHALL take effect only at the next accept.

Reset
REQ-035 reset SHALL force: state IDLE, bit_cnt=0, hist=0, hist_fill=0, pat_q=0, seq_seen=0, match_cnt=0, irq=0.
REQ-036 Because reset forces IDLE, word_ready SHALL be 1 in the cycle after reset.
REQ-037 Reset SHALL override all other inputs, including mid-word; the partial word is discarded.

Verification
REQ-038 pattern=4'b1011, accept 0xB0, enable=1 -> seq_seen pulses once, one cycle after the 4th bit consume; match_cnt=1.
REQ-039 pattern=4'b1011, word 0xB6 -> two seq_seen pulses, after consumes 4 and 7; match_cnt=2.
REQ-040 pattern=4'b1011, words 0x05 then 0x80 back-to-back -> word_ready high on the last bit of 0x05; one match, on the first bit of 0x80.
REQ-041 enable low 3 cycles mid-word -> ser_valid=0 and bit_cnt held for 3 cycles; match timing shifted exactly 3 cycles.
REQ-042 thresh=2, stream 0xB6 -> irq=1 the cycle after the 2nd match; irq_clr -> irq=0, match_cnt=0; 300 matches with thresh=0 -> match_cnt=255, irq=0.
REQ-043 reset after 3 bits of 0xB0 -> next-cycle IDLE, word_ready=1, match_cnt=0; re-sending 0xB0 gives exactly 1 match.
